// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of a UART transmitter.
// A producer writes bytes at full clock rate. The FIFO holds up to DEPTH of them.
// A three-state launcher hands one byte at a time to the UART over the
// tx_data/tx_en handshake.
//
// Handshake summary:
//   Producer side: a byte is accepted on a rising edge where wr_en=1 and full=0.
//     If wr_en=1 while full=1, the byte is dropped and overflow pulses in the next
//     cycle.
//   UART side: tx_en/tx_data are registered. Both are held constant from launch until
//     the cycle after tx_done.
//     The head entry is popped only when tx_done arrives in SEND, so count includes
//     the byte that is currently on the line.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [WIDTH-1:0]  tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    input  logic              tx_done
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Launcher state, kept as a named signal so checkers can bind to it.
    state_t             state_q;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [ADDR_W-1:0]  rptr_q, rptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   tx_data_q;
    logic               tx_en_q;
    logic               push;
    logic               pop;

    // Full is judged on the registered count only, so a same-cycle pop never makes room.
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;

    assign push = wr_en && !full;
    assign pop  = (state_q == ST_SEND) && tx_done;

    // Next-state for pointers, occupancy and the overflow pulse.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full;
        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wr_data;
        end
    end

    // Launcher: IDLE -> SEND on data and idle UART, SEND -> GAP on tx_done,
    // GAP -> IDLE once the UART reports not busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty && !tx_busy) begin
                        tx_data_q <= mem[rptr_q];
                        tx_en_q   <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        tx_en_q <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. It uses a per-cycle vector table for the handshake timing.
// Hand-written sequences cover overflow, the full boundary, reset mid-frame and
// pointer wrap.
// A behavioural UART stub consumes frames, and a negedge monitor checks the
// cycle invariants.
module tb_uart_tx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic [WIDTH-1:0] tx_data;
    logic             tx_en;
    logic             tx_busy;
    logic             tx_done;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    // Stub control and state
    logic auto_uart = 1'b0;
    logic stall     = 1'b0;
    int   frame_len = 3;
    logic stub_busy = 1'b0;
    int   stub_cnt  = 0;

    // Monitor state
    logic        ovf_allowed = 1'b0;
    logic        prev_en     = 1'b0;
    logic        prev_done   = 1'b0;
    logic [7:0]  prev_data   = 8'h00;
    int          peak_count  = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART stub: captures a byte at launch, stays busy for frame_len cycles, then pulses tx_done
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_uart) begin
                tx_done = 1'b0;
                if (stub_busy) begin
                    if (stub_cnt == 0) begin
                        tx_done   = 1'b1;
                        tx_busy   = 1'b0;
                        stub_busy = 1'b0;
                    end else begin
                        stub_cnt--;
                    end
                end else begin
                    tx_busy = stall;
                    if (tx_en && !stall) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rx_unexpected: got 0x%0h expected none at %0t", tx_data, $time);
                        end else begin
                            logic [WIDTH-1:0] e;
                            e = exp_q.pop_front();
                            if (tx_data !== e) begin
                                errors++;
                                $display("FAIL rx_data: got 0x%0h expected 0x%0h at %0t", tx_data, e, $time);
                            end
                        end
                        stub_busy = 1'b1;
                        tx_busy   = 1'b1;
                        stub_cnt  = frame_len;
                    end
                end
            end
        end
    end

    // Cycle invariants sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            prev_en   = 1'b0;
            prev_done = 1'b0;
        end else begin
            chk("count_le_depth", 32'(count <= 5'(DEPTH)), 32'd1);
            chk("full_flag", 32'(full), 32'(count == 5'(DEPTH)));
            chk("empty_flag", 32'(empty), 32'(count == 5'd0));
            if (overflow && !ovf_allowed) begin
                chk("spurious_overflow", 32'(overflow), 32'd0);
            end
            if (prev_en && tx_en) begin
                chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
            end
            if (prev_done && prev_en) begin
                chk("tx_en_gap", 32'(tx_en), 32'd0);
            end
            if (int'(count) > peak_count) peak_count = int'(count);
            prev_en   = tx_en;
            prev_done = tx_done;
            prev_data = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic expect_rx);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_rx) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (empty && !tx_en && !stub_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        if (!ok) exp_q.delete();
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       busy;
        logic       done;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_tx_en;
        logic [7:0] e_tx_data;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic b, input logic dn,
                                input logic [4:0] c, input logic em, input logic te, input logic [7:0] td);
        vec_t v;
        v.wr_en = w; v.wr_data = d; v.busy = b; v.done = dn;
        v.e_count = c; v.e_empty = em; v.e_full = 1'b0; v.e_ovf = 1'b0;
        v.e_tx_en = te; v.e_tx_data = td;
        return v;
    endfunction

    initial begin
        // Rows: inputs for one cycle, outputs expected just after that cycle's edge
        vecs[0]  = mk(1, 8'hA5, 0, 0, 1, 0, 0, 8'h00);
        vecs[1]  = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'hA5);
        vecs[2]  = mk(0, 8'h00, 1, 0, 1, 0, 1, 8'hA5);
        vecs[3]  = mk(1, 8'h3C, 1, 0, 2, 0, 1, 8'hA5);
        vecs[4]  = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'hA5);
        vecs[5]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 8'hA5);
        vecs[6]  = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h3C);
        vecs[7]  = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h3C);
        vecs[8]  = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h3C);
        vecs[9]  = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h3C);
        vecs[10] = mk(1, 8'h5A, 0, 0, 1, 0, 0, 8'h3C);
        vecs[11] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h5A);
        vecs[12] = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h5A);
        vecs[13] = mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h5A);
        vecs[14] = mk(1, 8'h66, 1, 0, 1, 0, 0, 8'h5A);
        vecs[15] = mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h5A);
        vecs[16] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h66);
        vecs[17] = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h66);
        vecs[18] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h66);

        // Clock/reset
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Table: launch latency, hold, pop, gap, tx_done outside SEND
        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
            tx_busy = vecs[i].busy; tx_done = vecs[i].done;
            tick();
            chk($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("row%0d full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("row%0d tx_en", i), 32'(tx_en), 32'(vecs[i].e_tx_en));
            chk($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_tx_data));
        end
        wr_en = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
        tick();

        // T2: burst of five, frames in order
        frame_len = 3; auto_uart = 1'b1; peak_count = 0;
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        wait_idle("t2_drain", 500);
        chk("t2_peak", 32'(peak_count), 32'd5);
        chk("t2_empty", 32'(empty), 32'd1);

        // T3: stalled UART, DEPTH+1 writes
        tick(); tick();
        auto_uart = 1'b0; tx_busy = 1'b1; tx_done = 1'b0; ovf_allowed = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            write_byte(8'(i), (i < DEPTH));
            if (i == DEPTH - 1) begin
                chk("t3_full", 32'(full), 32'd1);
                chk("t3_count16", 32'(count), 32'd16);
                chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
            end
            if (i == DEPTH) begin
                chk("t3_overflow", 32'(overflow), 32'd1);
                chk("t3_count_hold", 32'(count), 32'd16);
            end
        end
        tick();
        chk("t3_ovf_pulse_end", 32'(overflow), 32'd0);
        ovf_allowed = 1'b0;
        stall = 1'b0; auto_uart = 1'b1;
        wait_idle("t3_drain", 1000);

        // T4: full, with write and tx_done in the same cycle
        tick(); tick();
        auto_uart = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_byte(8'h20 + 8'(i), (i != 0));
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_tx_en", 32'(tx_en), 32'd1);
        chk("t4_tx_data", 32'(tx_data), 32'h20);
        ovf_allowed = 1'b1;
        wr_en = 1'b1; wr_data = 8'h99; tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count15", 32'(count), 32'd15);
        chk("t4_not_full", 32'(full), 32'd0);
        chk("t4_tx_en_low", 32'(tx_en), 32'd0);
        write_byte(8'h30, 1'b1);
        chk("t4_count16", 32'(count), 32'd16);
        chk("t4_full_again", 32'(full), 32'd1);
        chk("t4_ovf_clear", 32'(overflow), 32'd0);
        ovf_allowed = 1'b0;
        auto_uart = 1'b1;
        wait_idle("t4_drain", 1000);

        // T5: reset mid-frame
        tick(); tick();
        frame_len = 8;
        write_byte(8'h3C, 1'b1);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (stub_busy) begin seen = 1'b1; break; end
                tick();
            end
            chk("t5_frame_started", 32'(seen), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_tx_en_drop", 32'(tx_en), 32'd0);
        chk("t5_count0", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_tx_data0", 32'(tx_data), 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("t5_only_3c_sent", 32'(exp_q.size()), 32'd0);
        tick();
        frame_len = 3;
        write_byte(8'h7E, 1'b1);
        wait_idle("t5_after_reset", 500);

        // T6: 40-byte stream with stalls, pointers wrap
        begin
            int sent;
            sent = 0;
            frame_len = 2;
            for (int cyc = 0; cyc < 3000 && sent < 40; cyc++) begin
                if ($urandom_range(0, 15) == 0) stall = !stall;
                if (!full && $urandom_range(0, 3) != 0) begin
                    wr_en = 1'b1;
                    wr_data = 8'($urandom_range(0, 255));
                    exp_q.push_back(wr_data);
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
            end
            wr_en = 1'b0;
            stall = 1'b0;
            chk("t6_all_written", 32'(sent), 32'd40);
        end
        wait_idle("t6_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
